// File: rtl/pet_uart_pkg.sv
// Shared types and constants for the PET serial transmitter.
// Holds the FSM state type, the default bit period and the 8N1 frame length.
package pet_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // 115200 baud from a 100 MHz system clock
    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DATA_BITS            = 8;
    localparam int FRAME_BITS           = 10;

endpackage

// File: rtl/pet_tx_fifo.sv
// Single-clock byte FIFO feeding the transmitter. Writes to a full FIFO are
// dropped and latch a sticky overflow flag; reads from an empty FIFO are ignored.
module pet_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          wr_ok;
    logic          rd_ok;

    // Acceptance looks at the registered count only, so a simultaneous pop
    // never makes room for a write arriving while full.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (wr_en && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/pet_uart_tx.sv
// 8N1 serial transmitter with a small write FIFO. The FSM pops one byte per
// frame and chains frames back to back while the FIFO has data.
module pet_uart_tx
    import pet_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] DATA_IN,
    input  logic       WR_STRB,
    output logic       FULL,
    output logic       EMPTY,
    output logic       BUSY,
    output logic       OVERFLOW,
    output logic       TXD,
    output tx_state_t  state_dbg
);

    localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT    = 3'(DATA_BITS - 1);

    tx_state_t   state, state_next;
    logic [15:0] baud_cnt, baud_next;
    logic [2:0]  bit_idx, idx_next;
    logic [7:0]  shift_reg, shift_next;
    logic        txd_q, txd_next;
    logic        pop;
    logic        bit_done;
    logic        fifo_empty;
    logic        fifo_full;
    logic [7:0]  fifo_rd_data;

    pet_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .reset    (RESET),
        .wr_data  (DATA_IN),
        .wr_en    (WR_STRB),
        .rd_en    (pop),
        .rd_data  (fifo_rd_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (OVERFLOW)
    );

    assign bit_done  = (baud_cnt == 16'd0);
    assign FULL      = fifo_full;
    assign EMPTY     = fifo_empty;
    assign BUSY      = (state != ST_IDLE) || !fifo_empty;
    assign TXD       = txd_q;
    assign state_dbg = state;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_IDLE;
            baud_cnt  <= 16'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'd0;
            txd_q     <= 1'b1;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_idx   <= idx_next;
            shift_reg <= shift_next;
            txd_q     <= txd_next;
        end
    end

    // The line level is registered from the current state, so it trails the
    // state by one cycle; every bit still lasts exactly CLKS_PER_BIT cycles.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        idx_next   = bit_idx;
        shift_next = shift_reg;
        txd_next   = 1'b1;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                baud_next = 16'd0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_rd_data;
                    baud_next  = BAUD_RELOAD;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                txd_next = 1'b0;
                if (bit_done) begin
                    baud_next  = BAUD_RELOAD;
                    idx_next   = 3'd0;
                    state_next = ST_DATA;
                end else begin
                    baud_next = baud_cnt - 16'd1;
                end
            end
            ST_DATA: begin
                txd_next = shift_reg[bit_idx];
                if (bit_done) begin
                    baud_next = BAUD_RELOAD;
                    if (bit_idx == LAST_BIT) begin
                        idx_next   = 3'd0;
                        state_next = ST_STOP;
                    end else begin
                        idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt - 16'd1;
                end
            end
            ST_STOP: begin
                txd_next = 1'b1;
                if (bit_done) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_rd_data;
                        baud_next  = BAUD_RELOAD;
                        state_next = ST_START;
                    end else begin
                        baud_next  = 16'd0;
                        state_next = ST_IDLE;
                    end
                end else begin
                    baud_next = baud_cnt - 16'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                baud_next  = 16'd0;
                idx_next   = 3'd0;
            end
        endcase
    end

endmodule
